// File: rtl/uart_tx_engine.sv
// UART transmit serializer: drains a first-word-fall-through TX FIFO and shifts
// 16550-style frames (5-8 data bits, optional parity, 1/1.5/2 stop) onto tx.
module uart_tx_engine #(
   parameter int OVS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_pulse,
   input  logic [1:0] wls,
   input  logic       stb,
   input  logic       pen,
   input  logic       eps,
   input  logic       sticky_par,
   input  logic       set_break,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_dout,
   output logic       fifo_pop,
   output logic       tx,
   output logic       busy,
   output logic       temt
);

   localparam int TW = $clog2(OVS);
   localparam int SW = $clog2(2 * OVS) + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t          state_r, state_n;
   logic [TW-1:0]   tick_cnt_r, tick_cnt_n;
   logic [2:0]      bit_cnt_r, bit_cnt_n;
   logic [SW-1:0]   stop_len_r, stop_len_n;
   logic [SW-1:0]   stop_cnt_r, stop_cnt_n;
   logic [7:0]      shift_r, shift_n;
   logic [1:0]      wls_r, wls_n;
   logic            pen_r, pen_n;
   logic            par_bit_r, par_bit_n;
   logic            tx_r, tx_n;
   logic            pop_r, pop_n;
   logic            busy_r, busy_n;
   logic            load_s;
   logic            tick_last_s;
   logic            stop_last_s;

   // Parity over the transmitted bits only; bits above 5+w are masked off.
   function automatic logic par_calc(input logic [7:0] d, input logic [1:0] w,
                                     input logic e, input logic s);
      logic [7:0] m;
      logic       x;
      m = 8'hFF >> (2'd3 - w);
      x = ^(d & m);
      if (s) begin
         par_calc = ~e;
      end else if (e) begin
         par_calc = x;
      end else begin
         par_calc = ~x;
      end
   endfunction

   function automatic logic [SW-1:0] stop_ticks(input logic s, input logic [1:0] w);
      if (!s) begin
         stop_ticks = SW'(OVS);
      end else if (w == 2'd0) begin
         stop_ticks = SW'(OVS + OVS / 2);
      end else begin
         stop_ticks = SW'(2 * OVS);
      end
   endfunction

   assign tick_last_s = (tick_cnt_r == TW'(OVS - 1));
   assign stop_last_s = (stop_cnt_r == (stop_len_r - SW'(1)));

   // Next-state, counter and output-register computation.
   always_comb begin
      state_n    = state_r;
      tick_cnt_n = tick_cnt_r;
      bit_cnt_n  = bit_cnt_r;
      stop_len_n = stop_len_r;
      stop_cnt_n = stop_cnt_r;
      shift_n    = shift_r;
      wls_n      = wls_r;
      pen_n      = pen_r;
      par_bit_n  = par_bit_r;
      tx_n       = tx_r;
      pop_n      = 1'b0;
      busy_n     = busy_r;
      load_s     = 1'b0;
      if (baud_pulse) begin
         case (state_r)
            IDLE: begin
               if (!fifo_empty) begin
                  load_s = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end
            START: begin
               if (tick_last_s) begin
                  state_n    = DATA;
                  tick_cnt_n = '0;
                  tx_n       = shift_r[0];
               end else begin
                  tick_cnt_n = tick_cnt_r + TW'(1);
               end
            end
            DATA: begin
               if (tick_last_s) begin
                  tick_cnt_n = '0;
                  if (bit_cnt_r == ({1'b0, wls_r} + 3'd4)) begin
                     bit_cnt_n = 3'd0;
                     if (pen_r) begin
                        state_n = PARITY;
                        tx_n    = par_bit_r;
                     end else begin
                        state_n    = STOP;
                        tx_n       = 1'b1;
                        stop_cnt_n = '0;
                     end
                  end else begin
                     shift_n   = shift_r >> 1;
                     bit_cnt_n = bit_cnt_r + 3'd1;
                     tx_n      = shift_r[1];
                  end
               end else begin
                  tick_cnt_n = tick_cnt_r + TW'(1);
               end
            end
            PARITY: begin
               if (tick_last_s) begin
                  state_n    = STOP;
                  tick_cnt_n = '0;
                  stop_cnt_n = '0;
                  tx_n       = 1'b1;
               end else begin
                  tick_cnt_n = tick_cnt_r + TW'(1);
               end
            end
            STOP: begin
               if (stop_last_s) begin
                  stop_cnt_n = '0;
                  if (!fifo_empty) begin
                     load_s = 1'b1;
                  end else begin
                     state_n = IDLE;
                     busy_n  = 1'b0;
                  end
               end else begin
                  stop_cnt_n = stop_cnt_r + SW'(1);
               end
            end
            default: begin
               state_n = IDLE;
               tx_n    = 1'b1;
               busy_n  = 1'b0;
            end
         endcase
         // Load event: shared by IDLE and the final STOP tick for gapless frames.
         if (load_s) begin
            shift_n    = fifo_dout;
            wls_n      = wls;
            pen_n      = pen;
            par_bit_n  = par_calc(fifo_dout, wls, eps, sticky_par);
            stop_len_n = stop_ticks(stb, wls);
            tick_cnt_n = '0;
            bit_cnt_n  = 3'd0;
            stop_cnt_n = '0;
            state_n    = START;
            tx_n       = 1'b0;
            pop_n      = 1'b1;
            busy_n     = 1'b1;
         end else begin
            pop_n = 1'b0;
         end
      end else begin
         pop_n = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         tick_cnt_r <= '0;
         bit_cnt_r  <= 3'd0;
         stop_len_r <= '0;
         stop_cnt_r <= '0;
         shift_r    <= 8'd0;
         wls_r      <= 2'd0;
         pen_r      <= 1'b0;
         par_bit_r  <= 1'b0;
         tx_r       <= 1'b1;
         pop_r      <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_n;
         tick_cnt_r <= tick_cnt_n;
         bit_cnt_r  <= bit_cnt_n;
         stop_len_r <= stop_len_n;
         stop_cnt_r <= stop_cnt_n;
         shift_r    <= shift_n;
         wls_r      <= wls_n;
         pen_r      <= pen_n;
         par_bit_r  <= par_bit_n;
         tx_r       <= tx_n;
         pop_r      <= pop_n;
         busy_r     <= busy_n;
      end
   end

   assign tx       = tx_r & ~set_break;
   assign fifo_pop = pop_r;
   assign busy     = busy_r;
   assign temt     = (state_r == IDLE) & fifo_empty;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: small FIFO model, frames sampled at bit
// centres and compared with hand-built expected bit vectors.
module tb_uart_tx_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud_pulse;
   logic [1:0] wls;
   logic       stb;
   logic       pen;
   logic       eps;
   logic       sticky_par;
   logic       set_break;
   logic       fifo_empty;
   logic [7:0] fifo_dout;
   logic       fifo_pop;
   logic       tx;
   logic       busy;
   logic       temt;

   logic [7:0] mem [16];
   logic [7:0] wr_cnt = 8'd0;
   logic [7:0] rd_cnt = 8'd0;
   int         div    = 1;
   int         bcnt   = 0;
   int         n_vec  = 0;
   int         n_err  = 0;

   uart_tx_engine #(.OVS(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .baud_pulse (baud_pulse),
      .wls        (wls),
      .stb        (stb),
      .pen        (pen),
      .eps        (eps),
      .sticky_par (sticky_par),
      .set_break  (set_break),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_pop   (fifo_pop),
      .tx         (tx),
      .busy       (busy),
      .temt       (temt)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (wr_cnt == rd_cnt);
   assign fifo_dout  = mem[rd_cnt[3:0]];
   assign baud_pulse = (bcnt == 0);

   // FIFO read side: pop strobe advances the head.
   always @(posedge clk) begin
      if (fifo_pop && (wr_cnt != rd_cnt)) rd_cnt <= rd_cnt + 8'd1;
   end

   // Baud tick generator, one tick every div clocks.
   always @(negedge clk) begin
      if (bcnt >= div - 1) bcnt <= 0;
      else bcnt <= bcnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_cnt[3:0]] = b;
      wr_cnt = wr_cnt + 8'd1;
   endtask

   task automatic set_lcr(input logic [1:0] w, input logic s, input logic p,
                          input logic e, input logic sp);
      wls = w; stb = s; pen = p; eps = e; sticky_par = sp;
   endtask

   // Lengths/positions in ticks; break window in clocks from the start bit.
   task automatic run_frame(input string tag, input logic [31:0] exp_bits, input int nbits,
                            input int exp_len, input int exp_pops, input int exp_psum,
                            input int stop_from, input int brk_on, input int brk_off);
      int          t;
      int          pops;
      int          psum;
      int          stop_bad;
      int          brk_bad;
      logic [31:0] got;
      logic [31:0] mask;
      t = 0; pops = 0; psum = 0; stop_bad = 0; brk_bad = 0; got = 32'd0;
      mask = (nbits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
      for (int k = 0; k < 400 * div && tx !== 1'b0; k++) @(negedge clk);
      check_eq({tag, "_start"}, {31'd0, tx}, 32'd0);
      while (busy === 1'b1 && t < 2000) begin
         set_break = (t >= brk_on) && (t < brk_off);
         #1;
         if (set_break && tx !== 1'b0) brk_bad++;
         if ((t % (16 * div)) == 8 * div && (t / (16 * div)) < nbits) got[t / (16 * div)] = tx;
         if (fifo_pop === 1'b1) begin
            pops++;
            psum += t;
         end
         if (t >= stop_from * div && tx !== 1'b1) stop_bad++;
         t++;
         @(negedge clk);
      end
      set_break = 1'b0;
      check_eq({tag, "_bits"}, got & mask, exp_bits & mask);
      check_eq({tag, "_len"}, t, exp_len * div);
      check_eq({tag, "_pops"}, pops, exp_pops);
      check_eq({tag, "_popt"}, psum, exp_psum * div);
      check_eq({tag, "_stop"}, stop_bad, 0);
      check_eq({tag, "_brk"}, brk_bad, 0);
      check_eq({tag, "_temt"}, {31'd0, temt}, 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      set_break = 1'b0;
      set_lcr(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check_eq("rst_tx",   {31'd0, tx},       32'd1);
      check_eq("rst_busy", {31'd0, busy},     32'd0);
      check_eq("rst_pop",  {31'd0, fifo_pop}, 32'd0);
      check_eq("rst_temt", {31'd0, temt},     32'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 8N1 0xA5
      push(8'hA5);
      run_frame("8n1_a5", {1'b1, 8'hA5, 1'b0}, 10, 160, 1, 0, 144, -1, -1);

      // 8 data + parity, 0x07 has three ones
      set_lcr(2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
      push(8'h07);
      run_frame("par_even", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 176, 1, 0, 160, -1, -1);
      set_lcr(2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      push(8'h07);
      run_frame("par_odd", {1'b1, 1'b0, 8'h07, 1'b0}, 11, 176, 1, 0, 160, -1, -1);
      set_lcr(2'd3, 1'b0, 1'b1, 1'b1, 1'b1);
      push(8'h07);
      run_frame("par_stick", {1'b1, 1'b0, 8'h07, 1'b0}, 11, 176, 1, 0, 160, -1, -1);

      // 5 data bits, 1.5 stop bits
      set_lcr(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      push(8'h1F);
      run_frame("w5_s15", {1'b1, 5'h1F, 1'b0}, 7, 120, 1, 0, 96, -1, -1);

      // 5 data bits: masked-off upper bits must not affect even parity
      set_lcr(2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      push(8'hE0);
      run_frame("w5_mask", {1'b1, 1'b0, 5'h00, 1'b0}, 8, 128, 1, 0, 112, -1, -1);

      // three frames back-to-back
      set_lcr(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      push(8'h01);
      push(8'h02);
      push(8'h03);
      run_frame("b2b", {2'b00, 1'b1, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0},
                30, 480, 3, 480, 464, -1, -1);

      // break over bits 1-2; line resumes at bit 3
      push(8'hA5);
      run_frame("brk", {1'b1, 8'hA5, 1'b0} & 32'hFFFF_FFF9, 10, 160, 1, 0, 144, 20, 44);

      // baud tick every third clock
      div = 3;
      push(8'h5A);
      run_frame("div3", {1'b1, 8'h5A, 1'b0}, 10, 160, 1, 0, 144, -1, -1);
      div = 1;
      repeat (4) @(negedge clk);

      // reset mid-DATA; second byte starts on the first tick after release
      push(8'h3C);
      push(8'h81);
      for (int k = 0; k < 400 && tx !== 1'b0; k++) @(negedge clk);
      repeat (60) @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("rstmid_tx",   {31'd0, tx},   32'd1);
      check_eq("rstmid_busy", {31'd0, busy}, 32'd0);
      check_eq("rstmid_temt", {31'd0, temt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_restart_tx",  {31'd0, tx},       32'd0);
      check_eq("rst_restart_pop", {31'd0, fifo_pop}, 32'd1);
      run_frame("rst_frame", {1'b1, 8'h81, 1'b0}, 10, 160, 1, 0, 144, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Transmit serializer for the UART datapath. It drains the 16-deep, 8-bit transmit FIFO through its first-word-fall-through read port (`dout`, `empty`, `pop`) and shifts each byte onto the serial line. Frame format follows 16550 line-control fields, with 16 oversampling ticks per bit. It reports `busy` and `temt` (transmitter empty) to the register/interrupt logic.

## Interface

Parameters:
- OVS, 16, baud_pulse ticks per bit time; must be a power of two and at least 4.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- baud_pulse  in  1  one-clk-wide oversample tick; all state advances only on cycles where it is high
- wls  in  2  word length select: data bits = 5 + wls
- stb  in  1  stop bits: 0 gives 1 stop bit; 1 gives 2 stop bits, or 1.5 when wls=0
- pen  in  1  parity enable
- eps  in  1  even parity select
- sticky_par  in  1  stick parity
- set_break  in  1  force the line low
- fifo_empty  in  1  TX FIFO empty flag
- fifo_dout  in  8  TX FIFO head word, valid while fifo_empty=0
- fifo_pop  out  1  one-clk pop strobe to the TX FIFO
- tx  out  1  serial output, idle high
- busy  out  1  frame in progress
- temt  out  1  high when fifo_empty=1 and the engine is in IDLE

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - tick_cnt: log2(OVS) bits, counts baud_pulse ticks within a bit.
  - bit_cnt: 3 bits.
  - stop_len: 6 bits, holds the number of STOP ticks.
- Load event, in IDLE: on a cycle with baud_pulse=1 and fifo_empty=0:
  - latch fifo_dout into shift_reg;
  - latch wls, stb, pen, eps, sticky_par into frame registers;
  - clear tick_cnt and enter START.
- After a load, LCR input changes have no effect until the next load.
- Bit masking: data bits above 5+wls are ignored. Parity uses only the transmitted bits.
- START: drive tx_reg=0 for OVS ticks, then enter DATA.
- DATA:
  - drive tx_reg=shift_reg[0];
  - every OVS ticks, shift right and increment bit_cnt;
  - after 5+wls bits, go to PARITY if pen=1, else STOP.
- PARITY: drive the parity bit for OVS ticks, then enter STOP. Parity bit value:
  - sticky_par=1: the bit is ~eps;
  - otherwise eps=1: the bit is XOR of the data bits (even parity);
  - otherwise eps=0: the bit is XNOR of the data bits (odd parity).
- STOP: drive tx_reg=1 for stop_len ticks. stop_len is:
  - OVS when stb=0;
  - 2·OVS when stb=1 and wls≠0;
  - OVS+OVS/2 when stb=1 and wls=0.
- End of STOP, on the final tick:
  - if fifo_empty=0, perform the load event on that same tick and go directly to START (no idle gap between frames);
  - otherwise go to IDLE.
- tx = tx_reg & ~set_break.
  - set_break gates the line only. The state machine and FIFO pops continue normally.
- Frame length in ticks = OVS·(1 + 5 + wls + pen) + stop_len. Example: 8N1 is 160 ticks.

## Timing

- Reset values: tx=1, fifo_pop=0, busy=0, temt reflects fifo_empty, tx_reg=1, state IDLE, all counters 0.
- Reset mid-frame: tx returns to 1 asynchronously. The frame is abandoned and its byte is lost; no retransmit.
- fifo_pop is a registered pulse. It is high exactly one clk, on the cycle after the load cycle, for every load.
  - fifo_dout is sampled on the load cycle. This is valid because the FIFO head stays put until the pop.
- tx_reg changes only on clk edges where baud_pulse=1.
  - The start bit appears on tx one clk after the load cycle, together with fifo_pop.
- busy is high from the clk after the load until the clk after the final STOP tick.
  - It stays high across back-to-back frames.
- temt is combinational: (state==IDLE) & fifo_empty.
- baud_pulse=0: all state holds. baud_pulse tied high is legal; one tick then equals one clk.
- fifo_empty rising during a frame has no effect. A popped byte is always sent in full.

## Test plan

- Tie baud_pulse=1, use 8N1, push 0xA5. Required:
  - tx reads 0 (16 clk), then bits 1,0,1,0,0,1,0,1 (16 clk each), then 1 (16 clk);
  - fifo_pop=1 once;
  - busy is high for 160 clk, then temt=1.
- Use wls=3, pen=1, eps=1, data 0x07. Required: parity bit=1, frame 176 ticks. Repeat with eps=0: parity bit=0. Repeat with sticky_par=1, eps=1: parity bit=0.
- Use wls=0, stb=1, data 0x1F. Required:
  - only 5 data bits are sent;
  - the stop period is 24 ticks;
  - total frame is 120 ticks.
- Push 0x01, 0x02, 0x03, then run 8N1. Required:
  - three frames back-to-back with no idle tick between them;
  - three fifo_pop pulses, each 160 ticks apart;
  - busy stays high for 480 ticks.
- Assert set_break during a frame. Required: tx=0 throughout. After release, tx resumes the current bit position, and that frame's pop count is unchanged.
- Assert rst during DATA. Required: tx=1 and busy=0 immediately. After release with the FIFO non-empty, the next frame starts on the first baud_pulse.
